// File: rtl/gate_test_pkg.sv
// Shared definitions for the logic-gate IC test engine: function codes,
// sequencer states and the supported size limits.
package gate_test_pkg;

  localparam int MAX_GATES  = 8;
  localparam int MAX_INPUTS = 8;

  typedef enum logic [2:0] {
    FUNC_AND  = 3'd0,
    FUNC_OR   = 3'd1,
    FUNC_NAND = 3'd2,
    FUNC_NOR  = 3'd3,
    FUNC_XOR  = 3'd4,
    FUNC_XNOR = 3'd5,
    FUNC_NOT  = 3'd6,
    FUNC_RSVD = 3'd7
  } func_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_CHECK,
    ST_DONE
  } state_e;

endpackage

// File: rtl/gate_truth_eval.sv
// Expected output of one gate for the current input vector under the selected
// logic function. Shared by all gates since they all receive the same vector.
module gate_truth_eval
  import gate_test_pkg::*;
#(
  parameter int NUM_INPUTS = 2
) (
  input  logic [2:0]            func,
  input  logic [NUM_INPUTS-1:0] vec,
  output logic                  expected
);

  // NOT looks at bit 0 only; the reserved code never matches anything useful.
  always_comb begin
    expected = 1'b0;
    case (func)
      FUNC_AND:  expected = &vec;
      FUNC_OR:   expected = |vec;
      FUNC_NAND: expected = ~&vec;
      FUNC_NOR:  expected = ~|vec;
      FUNC_XOR:  expected = ^vec;
      FUNC_XNOR: expected = ~^vec;
      FUNC_NOT:  expected = ~vec[0];
      default:   expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_test_sequencer.sv
// Exhaustive input sweep over up to NUM_GATES identical gates, with a settle
// delay per vector, synchronised output compare and sticky per-gate results.
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int NUM_GATES     = 4,
  parameter int NUM_INPUTS    = 2,
  parameter int SETTLE_CYCLES = 50000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  input  logic [2:0]                      func,
  input  logic [NUM_GATES-1:0]            gate_en,
  input  logic [NUM_GATES-1:0]            dut_out,
  output logic [NUM_GATES*NUM_INPUTS-1:0] stim,
  output logic                            busy,
  output logic                            done,
  output logic [NUM_GATES-1:0]            pass_vec,
  output logic [NUM_GATES-1:0]            fail_vec,
  output logic                            pass,
  output logic                            fail
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int VEC_W = NUM_INPUTS + 1;

  state_e                state, state_next;
  logic                  launch;
  logic                  accept;
  logic [2:0]            func_q;
  logic [NUM_GATES-1:0]  en_q;
  logic [NUM_GATES-1:0]  sync1, sync2;
  logic [NUM_GATES-1:0]  fail_bits, fail_next, mismatch;
  logic [CNT_W-1:0]      settle_cnt;
  logic [VEC_W-1:0]      vec_idx, last_idx;
  logic [NUM_INPUTS-1:0] vec;
  logic                  settled, last_vec, expected, run_pass;

  // A start is taken only from a quiet IDLE; launch delays entry to APPLY by a cycle.
  assign accept   = (state == ST_IDLE) && start && !launch;
  assign settled  = (settle_cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign last_idx = (func_q == FUNC_NOT) ? VEC_W'(1) : VEC_W'((1 << NUM_INPUTS) - 1);
  assign last_vec = (func_q == FUNC_RSVD) || (vec_idx == last_idx);
  assign vec      = vec_idx[NUM_INPUTS-1:0];

  gate_truth_eval #(.NUM_INPUTS(NUM_INPUTS)) u_truth (
    .func     (func_q),
    .vec      (vec),
    .expected (expected)
  );

  assign mismatch  = en_q & (sync2 ^ {NUM_GATES{expected}});
  assign fail_next = (func_q == FUNC_RSVD) ? en_q : (fail_bits | mismatch);
  assign run_pass  = (|en_q) && (fail_next == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (launch) state_next = ST_APPLY;
      ST_APPLY: begin
        if (abort)        state_next = ST_IDLE;
        else if (settled) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (abort)         state_next = ST_IDLE;
        else if (last_vec) state_next = ST_DONE;
        else               state_next = ST_APPLY;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= '0;
      sync2      <= '0;
      launch     <= 1'b0;
      func_q     <= '0;
      en_q       <= '0;
      fail_bits  <= '0;
      settle_cnt <= '0;
      vec_idx    <= '0;
      pass_vec   <= '0;
      fail_vec   <= '0;
      pass       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      sync1      <= dut_out;
      sync2      <= sync1;
      launch     <= accept;
      settle_cnt <= (state == ST_APPLY && !settled) ? settle_cnt + CNT_W'(1) : '0;
      if (accept) begin
        func_q    <= func;
        en_q      <= gate_en;
        fail_bits <= '0;
        vec_idx   <= '0;
        pass_vec  <= '0;
        fail_vec  <= '0;
        pass      <= 1'b0;
        fail      <= 1'b0;
      end else if (state == ST_CHECK && !abort) begin
        fail_bits <= fail_next;
        vec_idx   <= vec_idx + VEC_W'(1);
        if (last_vec) begin
          pass_vec <= en_q & ~fail_next;
          fail_vec <= fail_next;
          pass     <= run_pass;
          fail     <= !run_pass;
        end
      end
    end
  end

  assign busy = (state == ST_APPLY) || (state == ST_CHECK);
  assign done = (state == ST_DONE);

  // Disabled gates and idle periods see all-zero drive.
  for (genvar g = 0; g < NUM_GATES; g++) begin : g_stim
    assign stim[g*NUM_INPUTS +: NUM_INPUTS] = (busy && en_q[g]) ? vec : '0;
  end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Two sequencer instances (4x2-input and 6x3-input) driven against simulated
// gate ICs, checked every cycle against a timeline model of the test run.
module tb_gate_test_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_s [2];
  logic       abort_s [2];
  logic [2:0] func_s  [2];
  logic [7:0] en_s    [2];

  logic [3:0]  dout_a, pv_a, fv_a;
  logic [7:0]  stim_a;
  logic        busy_a, done_a, pass_a, fail_a;
  logic [5:0]  dout_b, pv_b, fv_b;
  logic [17:0] stim_b;
  logic        busy_b, done_b, pass_b, fail_b;
  logic [63:0] obs [2];

  int          ic_type [2];
  logic [7:0]  sk0 [2], sk1 [2];

  int          total = 0, bad = 0;
  logic [43:0] seen_q [$];

  // Model state: t counts edges since the accepted start (-1 when idle).
  int          t [2], last_t [2];
  logic [7:0]  men [2], mfail [2], rpv [2], rfv [2];
  logic        rpass [2], rfail [2];
  logic        pst [2], pab [2], hp [2];
  logic [2:0]  pf [2];
  logic [7:0]  pen [2];

  always #5 clk = ~clk;

  gate_test_sequencer #(.NUM_GATES(4), .NUM_INPUTS(2), .SETTLE_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]), .func(func_s[0]),
    .gate_en(en_s[0][3:0]), .dut_out(dout_a), .stim(stim_a), .busy(busy_a), .done(done_a),
    .pass_vec(pv_a), .fail_vec(fv_a), .pass(pass_a), .fail(fail_a)
  );

  gate_test_sequencer #(.NUM_GATES(6), .NUM_INPUTS(3), .SETTLE_CYCLES(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]), .func(func_s[1]),
    .gate_en(en_s[1][5:0]), .dut_out(dout_b), .stim(stim_b), .busy(busy_b), .done(done_b),
    .pass_vec(pv_b), .fail_vec(fv_b), .pass(pass_b), .fail(fail_b)
  );

  function automatic int ng_of(input int i); return (i == 0) ? 4 : 6; endfunction
  function automatic int ni_of(input int i); return (i == 0) ? 2 : 3; endfunction
  function automatic int s_of(input int i);  return (i == 0) ? 4 : 5; endfunction

  function automatic logic truth_of(input int f, input int v, input int n);
    int ones;
    ones = $countones(v & ((1 << n) - 1));
    case (f)
      0: return ones == n;
      1: return ones != 0;
      2: return ones != n;
      3: return ones == 0;
      4: return ones[0];
      5: return !ones[0];
      6: return !v[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic ic_out(input int typ, input logic s0, input logic s1, input int v, input int n);
    if (s1) return 1'b1;
    if (s0) return 1'b0;
    return truth_of(typ, v, n);
  endfunction

  // Simulated IC sockets: each gate responds combinationally to its stim slice.
  always_comb begin
    for (int g = 0; g < 4; g++)
      dout_a[g] = ic_out(ic_type[0], sk0[0][g], sk1[0][g], int'(stim_a[g*2 +: 2]), 2);
    for (int g = 0; g < 6; g++)
      dout_b[g] = ic_out(ic_type[1], sk0[1][g], sk1[1][g], int'(stim_b[g*3 +: 3]), 3);
  end

  always_comb begin
    obs[0] = {busy_a, done_a, pass_a, fail_a, 4'b0, pv_a, 4'b0, fv_a, 36'b0, stim_a};
    obs[1] = {busy_b, done_b, pass_b, fail_b, 2'b0, pv_b, 2'b0, fv_b, 26'b0, stim_b};
  end

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic model_reset(input int i);
    t[i] = -1; last_t[i] = 0; men[i] = '0; mfail[i] = '0;
    rpv[i] = '0; rfv[i] = '0; rpass[i] = 1'b0; rfail[i] = 1'b0;
  endtask

  task automatic model_step(input int i);
    int v;
    if (t[i] < 0) begin
      if (pst[i]) begin
        t[i] = 0;
        men[i] = pen[i] & 8'((1 << ng_of(i)) - 1);
        rpv[i] = '0; rfv[i] = '0; rpass[i] = 1'b0; rfail[i] = 1'b0;
        v = (pf[i] == 3'd7) ? 1 : (pf[i] == 3'd6) ? 2 : (1 << ni_of(i));
        last_t[i] = v * (s_of(i) + 1);
        mfail[i] = '0;
        for (int g = 0; g < ng_of(i); g++)
          if (men[i][g]) begin
            if (pf[i] == 3'd7) mfail[i][g] = 1'b1;
            for (int k = 0; k < v; k++)
              if (ic_out(ic_type[i], sk0[i][g], sk1[i][g], k, ni_of(i)) != truth_of(int'(pf[i]), k, ni_of(i)))
                mfail[i][g] = 1'b1;
          end
      end
    end else if (t[i] == 0) begin
      t[i] = 1;
    end else if (t[i] <= last_t[i]) begin
      if (pab[i]) t[i] = -1;
      else begin
        t[i]++;
        if (t[i] == last_t[i] + 1) begin
          rfv[i] = mfail[i];
          rpv[i] = men[i] & ~mfail[i];
          rpass[i] = (men[i] != 0) && (mfail[i] == 0);
          rfail[i] = !rpass[i];
        end
      end
    end else begin
      t[i] = -1;
    end
  endtask

  function automatic logic [63:0] exp_obs(input int i);
    logic [63:0] e;
    int k;
    e = '0;
    if (t[i] >= 1 && t[i] <= last_t[i]) begin
      e[63] = 1'b1;
      k = (t[i] - 1) / (s_of(i) + 1);
      for (int g = 0; g < ng_of(i); g++)
        if (men[i][g]) e[43:0] = e[43:0] | (44'(k) << (g * ni_of(i)));
    end
    e[62] = (t[i] >= 1) && (t[i] == last_t[i] + 1);
    e[61] = rpass[i];
    e[60] = rfail[i];
    e[59:52] = rpv[i];
    e[51:44] = rfv[i];
    return e;
  endfunction

  // Inputs change just after posedge, so values seen here are what the next edge samples.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        model_reset(i);
      end else if (hp[i]) begin
        model_step(i);
      end
      check_output($sformatf("cycle_inst%0d", i), obs[i], exp_obs(i));
      pst[i] = start_s[i]; pab[i] = abort_s[i]; pf[i] = func_s[i]; pen[i] = en_s[i];
      hp[i] = rst_n;
    end
  end

  task automatic apply_stimulus(input int i, input logic [2:0] f, input logic [7:0] en,
                                input int poke_edge, input int abort_edge, input int max_e,
                                output int done_edge);
    logic [43:0] prev;
    @(posedge clk); #1;
    start_s[i] = 1'b1; func_s[i] = f; en_s[i] = en;
    @(posedge clk); #1;
    start_s[i] = 1'b0; func_s[i] = 3'($urandom); en_s[i] = 8'($urandom);
    done_edge = -1;
    seen_q.delete();
    prev = '1;
    for (int e = 1; e <= max_e && done_edge < 0; e++) begin
      @(posedge clk); #1;
      start_s[i] = (e == poke_edge);
      abort_s[i] = (e == abort_edge);
      @(negedge clk);
      if (obs[i][62]) done_edge = e;
      if (obs[i][63] && obs[i][43:0] != prev) begin
        seen_q.push_back(obs[i][43:0]);
        prev = obs[i][43:0];
      end
    end
    @(posedge clk); #1;
    start_s[i] = 1'b0; abort_s[i] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int de;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; abort_s[i] = 1'b0; func_s[i] = '0; en_s[i] = '0;
      ic_type[i] = 0; sk0[i] = '0; sk1[i] = '0; hp[i] = 1'b0;
      model_reset(i);
    end
    repeat (3) @(negedge clk);
    check_output("reset_a", obs[0], 64'h0);
    check_output("reset_b", obs[1], 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Good NAND2 IC.
    ic_type[0] = 2;
    apply_stimulus(0, 3'd2, 8'hF, 0, 0, 40, de);
    check_output("nand_done_edge", 64'(de), 64'(21));
    check_output("nand_pass", {pass_a, fail_a, pv_a, fv_a}, {1'b1, 1'b0, 4'hF, 4'h0});

    // NOR2 IC with gate 2 stuck at 0.
    ic_type[0] = 3; sk0[0] = 8'b0100;
    apply_stimulus(0, 3'd3, 8'hF, 0, 0, 40, de);
    check_output("nor_stuck", {pass_a, fail_a, pv_a, fv_a}, {1'b0, 1'b1, 4'b1011, 4'b0100});
    sk0[0] = '0;

    // Start while busy is ignored.
    ic_type[0] = 2;
    apply_stimulus(0, 3'd2, 8'hF, 7, 0, 40, de);
    check_output("busy_start_done_edge", 64'(de), 64'(21));

    // Abort sampled at the edge after the third APPLY cycle, then a clean run.
    apply_stimulus(0, 3'd2, 8'hF, 0, 3, 30, de);
    check_output("abort_no_done", 64'(de), 64'(-1));
    check_output("abort_idle_outputs", obs[0], 64'h0);
    apply_stimulus(0, 3'd2, 8'hF, 0, 0, 40, de);
    check_output("after_abort_done_edge", 64'(de), 64'(21));
    check_output("after_abort_pass", 64'(pass_a), 64'(1));

    // No gates enabled, then the reserved function code.
    apply_stimulus(0, 3'd2, 8'h0, 0, 0, 40, de);
    check_output("en0_fail", {pass_a, fail_a}, 2'b01);
    apply_stimulus(0, 3'd7, 8'hF, 0, 0, 40, de);
    check_output("func7_done_edge", 64'(de), 64'(6));
    check_output("func7_fail", {pass_a, fail_a, fv_a}, {1'b0, 1'b1, 4'hF});

    // NOT mode on the 6-gate instance: only bit 0 of each gate toggles.
    ic_type[1] = 6;
    apply_stimulus(1, 3'd6, 8'h3F, 0, 0, 40, de);
    check_output("not_done_edge", 64'(de), 64'(13));
    check_output("not_pass", 64'(pass_b), 64'(1));
    check_output("not_stim_count", 64'(seen_q.size()), 64'(2));
    check_output("not_stim_vec1", 64'(seen_q[1]), 64'h9249);

    // AND3 sweep: vectors 0..7 replicated on every gate.
    ic_type[1] = 0;
    apply_stimulus(1, 3'd0, 8'h3F, 0, 0, 60, de);
    check_output("and3_done_edge", 64'(de), 64'(49));
    check_output("and3_pass", 64'(pass_b), 64'(1));
    check_output("and3_stim_count", 64'(seen_q.size()), 64'(8));
    for (int k = 0; k < 8; k++)
      check_output($sformatf("and3_stim_%0d", k), 64'(seen_q[k]), 64'(k * 37449));

    // Asynchronous reset in the middle of a run.
    @(posedge clk); #1;
    start_s[0] = 1'b1; func_s[0] = 3'd2; en_s[0] = 8'hF;
    @(posedge clk); #1 start_s[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_output("rst_async_a", obs[0], 64'h0);
    check_output("rst_async_b", obs[1], 64'h0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Randomised runs, checked cycle by cycle against the model.
    for (int r = 0; r < 10; r++) begin
      int inst, f;
      inst = int'($urandom_range(0, 1));
      f = int'($urandom_range(0, 7));
      ic_type[inst] = ($urandom_range(0, 1) == 0) ? ((f > 6) ? 6 : f) : int'($urandom_range(0, 6));
      sk0[inst] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
      sk1[inst] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
      apply_stimulus(inst, 3'(f), 8'($urandom), int'($urandom_range(0, 9)),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0, 60, de);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_test_sequencer.md
# gate_test_sequencer

Parametrised logic-gate IC test engine for the tester top level. It drives an exhaustive input-vector sweep onto up to `NUM_GATES` identical `NUM_INPUTS`-input gates and waits a programmable settle time per vector. It compares each synchronised DUT output against the selected logic function and reports per-gate and overall pass/fail. It replaces the fixed per-IC-type checkers plus the free-running one-second result mux with a single start/done-controlled block.

## Interface
- `NUM_GATES`, default 4: gates tested in parallel, 1..8.
- `NUM_INPUTS`, default 2: inputs per gate, 1..8.
- `SETTLE_CYCLES`, default 50000: clocks each vector is held before sampling; minimum 3.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a test run.
- `abort` in 1: cancels a run in progress.
- `func` in 3: gate function code, sampled at start.
- `gate_en` in NUM_GATES: gates included in the test, sampled at start.
- `dut_out` in NUM_GATES: gate outputs from the IC socket; asynchronous to `clk`.
- `stim` out NUM_GATES*NUM_INPUTS: input drive, gate g on bits [g*NUM_INPUTS +: NUM_INPUTS].
- `busy` out 1: a run is in progress.
- `done` out 1: one-cycle pulse when a run completes.
- `pass_vec` out NUM_GATES: per-gate pass result.
- `fail_vec` out NUM_GATES: per-gate fail result.
- `pass` out 1: overall pass.
- `fail` out 1: overall fail.

## Operation
- Function codes:
  - 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR (odd parity), 5 XNOR.
  - 6 NOT: uses input bit 0 only; other input bits are driven 0; vectors 0..1.
  - 7 is reserved: the run ends at the first CHECK with `fail`=1 and `fail_vec`=`gate_en`.
- Vector count V = 2^NUM_INPUTS, or 2 for NOT. The vector index counts 0..V-1 and every enabled gate receives the same vector.
- Disabled gates are driven with `stim` bits 0 and are never flagged.
- `dut_out` passes through a 2-flop synchroniser before comparison.
- FSM states and transitions:
  - IDLE -> APPLY on `start`.
  - APPLY: drive the vector and count SETTLE_CYCLES clocks, then go to CHECK.
  - CHECK: compare the synchronised output with the expected value. On mismatch of an enabled gate, set that gate's sticky fail bit. Go to APPLY with the next index, or to DONE after index V-1.
  - DONE: one cycle, then IDLE.
- At DONE:
  - `pass_vec` = `gate_en` & ~failbits.
  - `fail_vec` = failbits.
  - `pass` = (`gate_en`≠0) and (failbits==0).
  - `fail` = ~`pass`.
- Results hold until the next accepted `start`, which clears all result outputs in the cycle it is sampled.
- `start` while `busy` is ignored. `func` and `gate_en` changes mid-run have no effect.
- `abort` while `busy`: go to IDLE next cycle, `stim` returns to 0, no `done` pulse, and results stay cleared (0). If `abort` and `start` arrive together in IDLE, `start` wins.
- `gate_en`=0 at start: the run executes normally and ends with `pass`=0, `fail`=1.

## Timing
- Reset values: `stim`=0, `busy`=0, `done`=0, all pass/fail outputs=0, state IDLE, counters 0.
- `start` sampled at edge 0: `busy`=1 and `stim`=vector 0 from edge 1.
- Each vector occupies SETTLE_CYCLES APPLY cycles plus 1 CHECK cycle. The sample used in CHECK reflects `dut_out` at least SETTLE_CYCLES-2 clocks after the vector changed.
- `done` and the results assert at edge V*(SETTLE_CYCLES+1)+1. `busy` drops at the same edge as `done`, and `stim` returns to 0 in that cycle.
- Settle counter width is $clog2(SETTLE_CYCLES+1). Vector counter width is NUM_INPUTS+1, so it cannot wrap before terminal detection.
- Reset asserted mid-run forces all outputs to their reset values immediately (asynchronously).

## Structure
- Package `gate_test_pkg` holds:
  - the `func` code constants/enum,
  - the FSM state typedef,
  - the max NUM_GATES/NUM_INPUTS constants.
- Sub-module `gate_truth_eval` is combinational. Inputs are `func` and the vector; output is the expected bit. It is instantiated once, because all gates share the vector.
- The synchroniser and per-gate fail latches live in the top module.

## Test plan
- Good NAND IC: model the DUT as 4×NAND2, `func`=2, `gate_en`=4'hF, SETTLE_CYCLES=4. Required: `done` at edge 21, `pass`=1, `pass_vec`=4'hF, `fail_vec`=0.
- Gate 2 output stuck at 0 on a NOR2 IC: `func`=3. Required: `fail`=1, `fail_vec`=4'b0100, `pass_vec`=4'b1011.
- NOT mode: NUM_GATES=6, `func`=6, `gate_en`=6'h3F. Required:
  - only stim bit 0 of each gate toggles;
  - `done` after 2 vectors, i.e. at edge 2*(SETTLE_CYCLES+1)+1;
  - `pass`=1.
- Abort at the third APPLY cycle. Required: `busy`=0 next cycle, `stim`=0, no `done` pulse, all results 0. A following `start` runs normally.
- Reset and boundary cases:
  - `rst_n` low mid-run: all outputs 0 immediately.
  - `start` during `busy`: ignored, with completion timing unchanged.
  - `gate_en`=0: `fail`=1.
  - `func`=7: `fail`=1.
- Parameter sweep: NUM_INPUTS=3 with AND. Required: 8 vectors are observed on `stim` in order 0..7, and `pass`=1.
